// File: rtl/sccomp_state_dump.sv
// End-of-run state dump for the single-cycle core: halts after STOP_INSTR retired
// instructions, then streams PC, INSTR, the register file and data memory as words.
module sccomp_state_dump #(
   parameter int unsigned STOP_INSTR = 10,
   parameter int unsigned DM_AW      = 7,
   parameter int unsigned DM_WORDS   = 1 << DM_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [31:0]      pc,
   input  logic [31:0]      instr,
   output logic             halt,
   output logic [4:0]       rf_raddr,
   input  logic [31:0]      rf_rdata,
   output logic [DM_AW-1:0] dm_raddr,
   input  logic [31:0]      dm_rdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last,
   output logic             done
);

   localparam logic [8:0]  IDX_PC    = 9'd0;
   localparam logic [8:0]  IDX_PCW   = 9'd1;
   localparam logic [8:0]  IDX_INSTR = 9'd2;
   localparam logic [8:0]  IDX_RF0   = 9'd3;
   localparam logic [8:0]  IDX_RFN   = 9'd34;
   localparam logic [8:0]  IDX_DM0   = 9'd35;
   localparam logic [8:0]  IDX_LAST  = 9'(34 + DM_WORDS);
   localparam logic [31:0] STOP_CNT  = 32'(STOP_INSTR);

   typedef enum logic [1:0] {
      S_RUN,
      S_DUMP,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [31:0] r_count;
   logic [8:0]  r_idx;
   logic [31:0] r_pc_snap;
   logic [31:0] r_instr_snap;

   logic w_at_stop;
   logic w_in_dump;
   logic w_is_rf;
   logic w_is_dm;
   logic w_fire;

   assign w_at_stop = (r_count == STOP_CNT);
   assign w_in_dump = (r_state == S_DUMP);
   assign w_is_rf   = w_in_dump && (r_idx >= IDX_RF0) && (r_idx <= IDX_RFN);
   assign w_is_dm   = w_in_dump && (r_idx >= IDX_DM0);
   assign w_fire    = w_in_dump && out_ready;

   // halt is combinational in RUN so the instruction at the stop PC never commits
   assign halt      = (r_state != S_RUN) || w_at_stop;
   assign out_valid = w_in_dump;
   assign out_last  = w_in_dump && (r_idx == IDX_LAST);
   assign done      = (r_state == S_DONE);

   assign rf_raddr  = w_is_rf ? 5'(r_idx - IDX_RF0) : '0;
   assign dm_raddr  = w_is_dm ? DM_AW'(r_idx - IDX_DM0) : '0;

   // Read data is stable while stalled because the core is frozen during the dump
   always_comb begin
      out_data = '0;
      if (w_in_dump) begin
         if (r_idx == IDX_PC)
            out_data = r_pc_snap;
         else if (r_idx == IDX_PCW)
            out_data = {2'b00, r_pc_snap[31:2]};
         else if (r_idx == IDX_INSTR)
            out_data = r_instr_snap;
         else if (r_idx == IDX_RF0)
            out_data = '0;
         else if (w_is_rf)
            out_data = rf_rdata;
         else
            out_data = dm_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_RUN;
         r_count      <= '0;
         r_idx        <= '0;
         r_pc_snap    <= '0;
         r_instr_snap <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_at_stop) begin
                  r_pc_snap    <= pc;
                  r_instr_snap <= instr;
                  r_idx        <= '0;
                  r_state      <= S_DUMP;
               end else if (step && (r_count < STOP_CNT)) begin
                  r_count <= r_count + 32'd1;
               end
            end
            S_DUMP: begin
               if (w_fire) begin
                  if (r_idx == IDX_LAST)
                     r_state <= S_DONE;
                  else
                     r_idx <= r_idx + 9'd1;
               end
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

endmodule

// File: doc/sccomp_state_dump.md
Name: sccomp_state_dump

Overview:
- Sits beside the single-cycle core (sccomp), downstream of its architectural state.
- Counts retired instructions. After STOP_INSTR instructions it freezes the core and captures PC and INSTR.
- It then walks the register file and data memory through read ports and streams everything out as a valid/ready word stream: header, 32 registers, DM_WORDS memory words.
- This replaces simulation-only end-of-run dumps with synthesizable hardware usable on FPGA via a UART/debug bridge.

Parameters:
- STOP_INSTR, 10, number of retired instructions before halt (0 = halt immediately after reset)
- DM_AW, 7, data-memory word-address width
- DM_WORDS, 1<<DM_AW (128), data-memory words dumped

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- step  in  1  core retired one instruction this cycle
- pc  in  32  core PC (address of instruction about to execute)
- instr  in  32  instruction at pc
- halt  out  1  freeze core: no PC/RF/DM update while 1
- rf_raddr  out  5  register-file debug read address
- rf_rdata  in  32  combinational RF read data
- dm_raddr  out  DM_AW  data-memory debug word address
- dm_rdata  in  32  combinational DM read data
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts word
- out_data  out  32  stream word
- out_last  out  1  final word of dump
- done  out  1  dump complete, sticky until rst

Behaviour:
- States: RUN, DUMP, DONE. Reset state is RUN.
- Reset values: count=0, idx=0, halt=0, out_valid=0, out_last=0, done=0, rf_raddr=0, dm_raddr=0.
- Reset is honoured in any state, including mid-dump. The partially sent stream is abandoned.
- RUN:
  - count (32b) increments on each cycle with step=1 while count<STOP_INSTR.
  - halt = (count==STOP_INSTR), combinational, so the instruction at the stop PC never commits.
  - In the first cycle count==STOP_INSTR: register pc_snap=pc and instr_snap=instr; set idx=0; go to DUMP.
  - step is ignored while halt=1.
- DUMP:
  - halt=1 and out_valid=1.
  - idx (9b) advances only on an out_valid&out_ready handshake.
  - Beat map:
    - idx 0 → pc_snap
    - idx 1 → pc_snap>>2
    - idx 2 → instr_snap
    - idx 3..34 → register idx-3; rf_raddr=idx-3; register 0 is forced to 0 regardless of rf_rdata
    - idx 35..34+DM_WORDS → dm_rdata; dm_raddr=idx-35
  - rf_raddr is 0 outside register beats; dm_raddr is 0 outside memory beats.
  - out_data is muxed combinationally from idx and the read data. It is stable while ready is low because the core is frozen.
  - out_last=1 only when idx=34+DM_WORDS.
  - Handshake on the last beat → DONE next cycle.
  - Holding rules while out_ready=0: out_valid stays 1, and out_data, idx and addresses hold.
- DONE: halt=1, done=1, out_valid=0, out_last=0. Stays here until rst.
- Total beats: 35+DM_WORDS (163 at default). Minimum dump time equals the beat count, at one beat per cycle with out_ready tied 1.
- No wrap-around:
  - count saturates at STOP_INSTR.
  - idx never exceeds 34+DM_WORDS.

Test Plan:
1. STOP_INSTR=10; step=1 every cycle; pc=4*n, instr=0x00100093+n → halt rises combinationally after 10 steps with pc=0x28. First beats are 0x00000028, 0x0000000A, 0x0010009D.
2. out_ready low 5 cycles during beat 1 → out_valid stays 1, out_data holds 0x0000000A, rf_raddr/dm_raddr unchanged. Beat 2 follows the first ready cycle.
3. RF model returns 0xDEAD0000|addr → beat 3=0x00000000 and rf_raddr=0; beat 4=0xDEAD0001; beat 34=0xDEAD001F with rf_raddr=31.
4. DM model dmem[i]=i*4, out_ready=1 → beats 35..162 = 0x000..0x1FC with dm_raddr=0..127. out_last is only on beat 162, done=1 the next cycle, 163 beats total.
5. step high only on alternate cycles → halt asserts after the 10th step, i.e. about 20 clocks, not 10. No pc change is accepted once halt=1.
6. rst pulse during register beats → next cycle halt=0, out_valid=0, done=0, count=0. A re-run with the same stimulus yields a bit-identical stream. Separately, STOP_INSTR=0 → halt=1 in the first cycle after reset, and beat 0 equals pc in that cycle.
